placer_req_driver: RTL and testbench

- Request sequencer and response collector that sits on the opposite side of the sticker-placer interface from `M216A_TopModule`.
- Accepts placement requests (height, width) on a valid/ready stream and presents them to the placer at its fixed 4-cycle slot cadence, inserting idle (0,0) slots when it has nothing to send.
- Samples the placer's (index_x, index_y, strike) result a fixed latency after each issued slot and returns it on a valid/ready response stream.
- Replaces the file-driven bench stimulus when the placer is driven on-chip (e.g. from a UART bridge).

---
 rtl/placer_pkg.sv | 34 +++
 rtl/placer_req_driver_if.sv | 42 ++++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/placer_req_driver.sv | 122 ++++++++++++
 tb/tb_placer_req_driver.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/placer_pkg.sv
// ============================================================
// placer_pkg : shared widths, idle code and request/response records
// Rev 1.0
// ============================================================
`default_nettype none

package placer_pkg;

  localparam int DIM_W       = 5;
  localparam int IDX_W       = 8;
  localparam int STRIKE_W    = 4;
  localparam int SLOT_CYCLES = 4;

  localparam logic [DIM_W-1:0] DIM_IDLE = '0;

  typedef struct packed {
    logic [DIM_W-1:0] height;
    logic [DIM_W-1:0] width;
  } place_req_t;

  typedef struct packed {
    logic [IDX_W-1:0]    x;
    logic [IDX_W-1:0]    y;
    logic [STRIKE_W-1:0] strike;
  } place_rsp_t;

  // A request with either dimension at the idle code can never be placed.
  function automatic logic dims_ok(input place_req_t r);
    return (r.height != DIM_IDLE) && (r.width != DIM_IDLE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/placer_req_driver_if.sv
// ============================================================
// placer_req_driver_if : request/response streams and placer-side bus
// Rev 1.0
// ============================================================
`default_nettype none

interface placer_req_driver_if;
  import placer_pkg::*;

  logic                req_valid_i;
  logic                req_ready_o;
  logic [DIM_W-1:0]    req_height_i;
  logic [DIM_W-1:0]    req_width_i;
  logic [DIM_W-1:0]    height_o;
  logic [DIM_W-1:0]    width_o;
  logic [IDX_W-1:0]    index_x_i;
  logic [IDX_W-1:0]    index_y_i;
  logic [STRIKE_W-1:0] strike_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [IDX_W-1:0]    rsp_index_x_o;
  logic [IDX_W-1:0]    rsp_index_y_o;
  logic [STRIKE_W-1:0] rsp_strike_o;
  logic                bad_req_o;

  modport slave (
    input  req_valid_i, req_height_i, req_width_i,
    input  index_x_i, index_y_i, strike_i, rsp_ready_i,
    output req_ready_o, height_o, width_o,
    output rsp_valid_o, rsp_index_x_o, rsp_index_y_o, rsp_strike_o, bad_req_o
  );

  modport master (
    output req_valid_i, req_height_i, req_width_i,
    output index_x_i, index_y_i, strike_i, rsp_ready_i,
    input  req_ready_o, height_o, width_o,
    input  rsp_valid_o, rsp_index_x_o, rsp_index_y_o, rsp_strike_o, bad_req_o
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================
// sync_fifo : valid/ready FIFO, no pass-through, head reads zero after reset
// Rev 1.0
// ============================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready_o  = (count_q != CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (w_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/placer_req_driver.sv
// ============================================================
// placer_req_driver : feeds requests to the placer on its slot cadence
//                     and collects the results in issue order
// Rev 1.0
// ============================================================
`default_nettype none

module placer_req_driver
  import placer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = 8,
  parameter int SLOT    = SLOT_CYCLES
) (
  input  logic               clk_i,
  input  logic               rst_i,
  placer_req_driver_if.slave bus
);

  localparam int PH_W  = (SLOT > 1) ? $clog2(SLOT) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  place_req_t       w_req_in;
  place_req_t       w_req_head;
  place_rsp_t       w_rsp_in;
  place_rsp_t       w_rsp_head;
  logic             w_req_ready;
  logic             w_req_valid;
  logic             w_req_pop;
  logic             w_rsp_ready;
  logic             w_rsp_valid;
  logic             w_rsp_push;
  logic             w_rsp_pop;
  logic             w_issue_edge;
  logic             w_issue;
  logic             w_discard;

  logic [PH_W-1:0]    phase_q, phase_d;
  logic [LATENCY-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic [DIM_W-1:0]   height_q;
  logic [DIM_W-1:0]   width_q;
  logic               bad_req_q;

  assign w_req_in = '{height: bus.req_height_i, width: bus.req_width_i};
  assign w_rsp_in = '{x: bus.index_x_i, y: bus.index_y_i, strike: bus.strike_i};

  sync_fifo #(.WIDTH($bits(place_req_t)), .DEPTH(DEPTH)) u_req_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (bus.req_valid_i & rst_i),
    .in_ready_o  (w_req_ready),
    .in_data_i   (w_req_in),
    .out_valid_o (w_req_valid),
    .out_ready_i (w_req_pop),
    .out_data_o  (w_req_head)
  );

  sync_fifo #(.WIDTH($bits(place_rsp_t)), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (w_rsp_push & w_rsp_ready),
    .in_ready_o  (w_rsp_ready),
    .in_data_i   (w_rsp_in),
    .out_valid_o (w_rsp_valid),
    .out_ready_i (bus.rsp_ready_i),
    .out_data_o  (w_rsp_head)
  );

  // outst_q counts slots in flight plus responses still queued, so one
  // registered compare enforces the shared credit without a same-cycle path.
  assign w_issue_edge = (phase_q == PH_W'(SLOT - 1));
  assign w_issue      = w_issue_edge & w_req_valid & dims_ok(w_req_head)
                        & (outst_q < CNT_W'(DEPTH));
  assign w_discard    = w_req_valid & ~dims_ok(w_req_head);
  assign w_req_pop    = w_issue | w_discard;
  assign w_rsp_push   = sr_q[LATENCY-1];
  assign w_rsp_pop    = w_rsp_valid & bus.rsp_ready_i;

  always_comb begin
    phase_d = w_issue_edge ? '0 : phase_q + 1'b1;
    sr_d    = (sr_q << 1) | LATENCY'(w_issue);
    outst_d = outst_q;
    case ({w_issue, w_rsp_pop})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      phase_q   <= '0;
      sr_q      <= '0;
      outst_q   <= '0;
      height_q  <= DIM_IDLE;
      width_q   <= DIM_IDLE;
      bad_req_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      sr_q      <= sr_d;
      outst_q   <= outst_d;
      bad_req_q <= bad_req_q | w_discard;
      if (w_issue_edge) begin
        height_q <= w_issue ? w_req_head.height : DIM_IDLE;
        width_q  <= w_issue ? w_req_head.width  : DIM_IDLE;
      end
    end
  end

  assign bus.req_ready_o   = w_req_ready & rst_i;
  assign bus.height_o      = height_q;
  assign bus.width_o       = width_q;
  assign bus.rsp_valid_o   = w_rsp_valid;
  assign bus.rsp_index_x_o = w_rsp_head.x;
  assign bus.rsp_index_y_o = w_rsp_head.y;
  assign bus.rsp_strike_o  = w_rsp_head.strike;
  assign bus.bad_req_o     = bad_req_q;

endmodule

`default_nettype wire

// File: tb/tb_placer_req_driver.sv
// ============================================================
// tb_placer_req_driver : directed scenarios against a delayed placer model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_placer_req_driver;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  placer_req_driver_if bus();

  placer_req_driver #(.DEPTH(4), .LATENCY(8), .SLOT(4)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Placer stand-in: answers from the slot values seen a few cycles earlier.
  function automatic logic [7:0] mx(input logic [4:0] h); return {1'b0, h, 2'b00}; endfunction
  function automatic logic [7:0] my(input logic [4:0] w); return {3'b000, w} - 8'd5; endfunction
  function automatic logic [3:0] ms(input logic [4:0] h); return h[3:0] ^ 4'd3; endfunction

  logic [9:0] dly [4];
  always @(posedge clk) begin
    dly[0] <= {bus.height_o, bus.width_o};
    for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
  end
  assign bus.index_x_i = mx(dly[3][9:5]);
  assign bus.index_y_i = my(dly[3][4:0]);
  assign bus.strike_i  = ms(dly[3][9:5]);

  logic [9:0] prev_hw = '0;
  int         launch_cnt = 0;
  always @(negedge clk) begin
    if ({bus.height_o, bus.width_o} != 10'd0 && {bus.height_o, bus.width_o} != prev_hw)
      launch_cnt <= launch_cnt + 1;
    prev_hw <= {bus.height_o, bus.width_o};
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push(input logic [4:0] h, input logic [4:0] w);
    bus.req_valid_i  = 1'b1;
    bus.req_height_i = h;
    bus.req_width_i  = w;
    for (int i = 0; i < 64; i++) begin
      if (bus.req_ready_o) begin
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.req_valid_i = 1'b0;
    checks++; errors++;
    $display("FAIL push_timeout: request (%0d,%0d) not accepted, required accept within 64 cycles", h, w);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid_i = 1'b1; bus.req_height_i = 5'd4; bus.req_width_i = 5'd4;
    bus.rsp_ready_i = 1'b0;
    step(3);
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %0b required 0", bus.req_ready_o); end
    checks++; if (bus.height_o !== 5'd0) begin errors++; $display("FAIL rst_height: got %0d required 0", bus.height_o); end
    checks++; if (bus.width_o !== 5'd0) begin errors++; $display("FAIL rst_width: got %0d required 0", bus.width_o); end
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b required 0", bus.rsp_valid_o); end
    checks++; if (bus.bad_req_o !== 1'b0) begin errors++; $display("FAIL rst_bad_req: got %0b required 0", bus.bad_req_o); end
    checks++; if (bus.rsp_index_x_o !== 8'd0) begin errors++; $display("FAIL rst_rsp_x: got %0d required 0", bus.rsp_index_x_o); end
    bus.req_valid_i = 1'b0;
    step(1);
  endtask

  task automatic test_single_request();
    int d;
    int k;
    do_reset();
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %0b required 1", bus.req_ready_o); end
    push(5'd3, 5'd5);
    d = 0;
    while (bus.height_o == 5'd0 && d < 8) begin step(1); d++; end
    checks++; if (d !== 2) begin errors++; $display("FAIL single_launch_delay: got %0d cycles required 2", d); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.height_o, bus.width_o} !== {5'd3, 5'd5}) begin
        errors++; $display("FAIL single_slot_hold%0d: got %0d/%0d required 3/5", i, bus.height_o, bus.width_o);
      end
      step(1);
    end
    checks++; if ({bus.height_o, bus.width_o} !== 10'd0) begin errors++; $display("FAIL single_slot_idle: got %0d/%0d required 0/0", bus.height_o, bus.width_o); end
    k = 4;
    while (!bus.rsp_valid_o && k < 20) begin step(1); k++; end
    checks++; if (k !== 8) begin errors++; $display("FAIL single_rsp_latency: got %0d cycles required 8", k); end
    checks++;
    if ({bus.rsp_index_x_o, bus.rsp_index_y_o, bus.rsp_strike_o} !== {8'd12, 8'd0, 4'd0}) begin
      errors++; $display("FAIL single_rsp_data: got %0d/%0d/%0d required 12/0/0", bus.rsp_index_x_o, bus.rsp_index_y_o, bus.rsp_strike_o);
    end
    bus.rsp_ready_i = 1'b1; step(1); bus.rsp_ready_i = 1'b0;
    checks++; if (bus.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_rsp_drained: got %0b required 0", bus.rsp_valid_o); end
  endtask

  task automatic test_bad_request();
    logic launched;
    int   k;
    launched = 1'b0;
    push(5'd0, 5'd7);
    for (int i = 0; i < 8; i++) begin
      if (bus.height_o != 5'd0) launched = 1'b1;
      step(1);
    end
    checks++; if (launched !== 1'b0) begin errors++; $display("FAIL bad_no_slot: got launch=%0b required 0", launched); end
    checks++; if (bus.bad_req_o !== 1'b1) begin errors++; $display("FAIL bad_flag_set: got %0b required 1", bus.bad_req_o); end
    push(5'd2, 5'd2);
    k = 0;
    while (bus.height_o == 5'd0 && k < 8) begin step(1); k++; end
    checks++; if ({bus.height_o, bus.width_o} !== {5'd2, 5'd2}) begin errors++; $display("FAIL bad_next_issue: got %0d/%0d required 2/2", bus.height_o, bus.width_o); end
    k = 0;
    while (!bus.rsp_valid_o && k < 20) begin step(1); k++; end
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_index_x_o, bus.rsp_index_y_o, bus.rsp_strike_o} !== {1'b1, 8'd8, 8'd253, 4'd1}) begin
      errors++; $display("FAIL bad_next_rsp: got v=%0b %0d/%0d/%0d required v=1 8/253/1", bus.rsp_valid_o, bus.rsp_index_x_o, bus.rsp_index_y_o, bus.rsp_strike_o);
    end
    bus.rsp_ready_i = 1'b1; step(1); bus.rsp_ready_i = 1'b0;
    checks++; if (bus.bad_req_o !== 1'b1) begin errors++; $display("FAIL bad_flag_sticky: got %0b required 1", bus.bad_req_o); end
  endtask

  task automatic test_back_pressure();
    logic [4:0]  hs [5] = '{5'd1, 5'd2, 5'd4, 5'd6, 5'd7};
    logic [4:0]  ws [5] = '{5'd1, 5'd3, 5'd6, 5'd9, 5'd12};
    logic [19:0] exp_rsp [5] = '{{8'd4, 8'd252, 4'd2}, {8'd8, 8'd254, 4'd1}, {8'd16, 8'd1, 4'd7},
                                 {8'd24, 8'd4, 4'd5}, {8'd28, 8'd7, 4'd4}};
    int base;
    int k;
    bus.rsp_ready_i = 1'b0;
    base = launch_cnt;
    for (int i = 0; i < 5; i++) push(hs[i], ws[i]);
    step(40);
    checks++; if (launch_cnt - base !== 4) begin errors++; $display("FAIL bp_launch_count: got %0d required 4", launch_cnt - base); end
    checks++; if (bus.height_o !== 5'd0) begin errors++; $display("FAIL bp_fifth_held: got height %0d required 0", bus.height_o); end
    checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_rsp_queued: got %0b required 1", bus.rsp_valid_o); end
    for (int i = 0; i < 5; i++) begin
      k = 0;
      while (!bus.rsp_valid_o && k < 24) begin step(1); k++; end
      checks++;
      if ({bus.rsp_index_x_o, bus.rsp_index_y_o, bus.rsp_strike_o} !== exp_rsp[i] || !bus.rsp_valid_o) begin
        errors++; $display("FAIL bp_rsp%0d: got v=%0b %0h required %0h", i, bus.rsp_valid_o,
                           {bus.rsp_index_x_o, bus.rsp_index_y_o, bus.rsp_strike_o}, exp_rsp[i]);
      end
      bus.rsp_ready_i = 1'b1; step(1); bus.rsp_ready_i = 1'b0;
      if (i == 0) begin
        k = 0;
        while (bus.height_o == 5'd0 && k < 9) begin step(1); k++; end
        checks++; if ({bus.height_o, bus.width_o} !== {5'd7, 5'd12}) begin errors++; $display("FAIL bp_fifth_launch: got %0d/%0d required 7/12", bus.height_o, bus.width_o); end
      end
    end
  endtask

  task automatic test_reset_mid_flight();
    logic seen;
    int   k;
    seen = 1'b0;
    bus.rsp_ready_i = 1'b0;
    push(5'd3, 5'd1);
    push(5'd5, 5'd2);
    push(5'd9, 5'd4);
    k = 0;
    while (!bus.rsp_valid_o && k < 30) begin step(1); k++; end
    checks++; if (bus.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL mid_first_rsp: got %0b required 1", bus.rsp_valid_o); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.rsp_valid_o, bus.height_o, bus.bad_req_o} !== 7'd0) begin
      errors++; $display("FAIL mid_async_clear: got v=%0b h=%0d bad=%0b required 0/0/0", bus.rsp_valid_o, bus.height_o, bus.bad_req_o);
    end
    step(1);
    rst_n = 1'b1;
    bus.rsp_ready_i = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.rsp_valid_o || bus.height_o != 5'd0) seen = 1'b1;
      step(1);
    end
    bus.rsp_ready_i = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got activity=%0b required 0", seen); end
  endtask

  task automatic test_req_fifo_full();
    logic rdy_seen;
    logic accepted;
    rdy_seen = 1'b0;
    accepted = 1'b0;
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(5'd1, 5'(i + 2));
    step(30);
    for (int i = 0; i < 4; i++) push(5'd2, 5'(i + 1));
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %0b required 0", bus.req_ready_o); end
    bus.req_valid_i = 1'b1; bus.req_height_i = 5'd3; bus.req_width_i = 5'd3;
    for (int i = 0; i < 12; i++) begin
      if (bus.req_ready_o) rdy_seen = 1'b1;
      step(1);
    end
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL full_held: got ready=%0b required 0", rdy_seen); end
    checks++;
    if ({bus.rsp_index_x_o, bus.rsp_index_y_o, bus.rsp_strike_o} !== {8'd4, 8'd253, 4'd2}) begin
      errors++; $display("FAIL full_head_rsp: got %0d/%0d/%0d required 4/253/2", bus.rsp_index_x_o, bus.rsp_index_y_o, bus.rsp_strike_o);
    end
    bus.rsp_ready_i = 1'b1; step(1); bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      if (bus.req_ready_o) accepted = 1'b1;
      step(1);
    end
    bus.req_valid_i = 1'b0;
    checks++; if (accepted !== 1'b1) begin errors++; $display("FAIL full_accept_after_issue: got %0b required 1", accepted); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.req_valid_i  = 1'b0;
    bus.req_height_i = '0;
    bus.req_width_i  = '0;
    bus.rsp_ready_i  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_request();
    test_bad_request();
    test_back_pressure();
    test_reset_mid_flight();
    test_req_fifo_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
